// File: rtl/lsu.sv
// Load/store unit: accepts one load or store at a time, checks alignment,
// drives a word-aligned byte-enabled access to the data memory and returns
// an extended load result or store completion over a valid/ready handshake.
module lsu #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [2:0]            req_funct3,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   input  logic [4:0]            req_rd,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_WIDTH-1:0] resp_data,
   output logic [4:0]            resp_rd,
   output logic                  resp_err,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_rd_data,
   output logic                  mem_wr_en,
   output logic [ADDR_WIDTH-1:0] mem_wr_addr,
   output logic [DATA_WIDTH-1:0] mem_wr_data,
   output logic [3:0]            mem_byte_en
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic                    we_q, we_d;
   logic [2:0]              funct3_q, funct3_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [4:0]              rd_q, rd_d;
   logic [DATA_WIDTH-1:0]   resp_data_q, resp_data_d;
   logic                    resp_err_q, resp_err_d;

   logic                    err_s;
   logic [DATA_WIDTH-1:0]   shifted_s;
   logic [DATA_WIDTH-1:0]   load_s;
   logic [DATA_WIDTH-1:0]   lane_data_s;
   logic [3:0]              lane_be_s;
   logic                    wr_s;

   // Decode the latched request: legality, alignment, store lanes, load extension.
   always_comb begin
      err_s       = 1'b0;
      load_s      = {DATA_WIDTH{1'b0}};
      lane_data_s = {DATA_WIDTH{1'b0}};
      lane_be_s   = 4'b0000;
      shifted_s   = mem_rd_data >> {addr_q[1:0], 3'b000};
      case (funct3_q)
         3'b000: begin
            load_s      = {{24{shifted_s[7]}}, shifted_s[7:0]};
            lane_data_s = {4{wdata_q[7:0]}};
            lane_be_s   = 4'b0001 << addr_q[1:0];
         end
         3'b001: begin
            err_s       = addr_q[0];
            load_s      = {{16{shifted_s[15]}}, shifted_s[15:0]};
            lane_data_s = {2{wdata_q[15:0]}};
            lane_be_s   = addr_q[1] ? 4'b1100 : 4'b0011;
         end
         3'b010: begin
            err_s       = (addr_q[1:0] != 2'b00);
            load_s      = shifted_s;
            lane_data_s = wdata_q;
            lane_be_s   = 4'b1111;
         end
         3'b100: begin
            err_s  = we_q;
            load_s = {24'h000000, shifted_s[7:0]};
         end
         3'b101: begin
            err_s  = we_q | addr_q[0];
            load_s = {16'h0000, shifted_s[15:0]};
         end
         default: begin
            err_s = 1'b1;
         end
      endcase
   end

   // Next-state and capture logic of the request/response FSM.
   always_comb begin
      state_d     = state_q;
      we_d        = we_q;
      funct3_d    = funct3_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rd_d        = rd_q;
      resp_data_d = resp_data_q;
      resp_err_d  = resp_err_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               we_d     = req_we;
               funct3_d = req_funct3;
               addr_d   = req_addr;
               wdata_d  = req_wdata;
               rd_d     = req_rd;
               state_d  = ACCESS;
            end else begin
               state_d  = IDLE;
            end
         end
         ACCESS: begin
            resp_err_d  = err_s;
            resp_data_d = (err_s || we_q) ? {DATA_WIDTH{1'b0}} : load_s;
            state_d     = RESP;
         end
         RESP: begin
            if (resp_ready) begin
               state_d = IDLE;
            end else begin
               state_d = RESP;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and latched-request registers; reset drops any in-flight work.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         we_q        <= 1'b0;
         funct3_q    <= 3'b000;
         addr_q      <= {ADDR_WIDTH{1'b0}};
         wdata_q     <= {DATA_WIDTH{1'b0}};
         rd_q        <= 5'd0;
         resp_data_q <= {DATA_WIDTH{1'b0}};
         resp_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         we_q        <= we_d;
         funct3_q    <= funct3_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rd_q        <= rd_d;
         resp_data_q <= resp_data_d;
         resp_err_q  <= resp_err_d;
      end
   end

   // Write strobe decodes straight from state so reset removes it at once.
   assign wr_s        = (state_q == ACCESS) && we_q && !err_s;
   assign mem_wr_en   = wr_s;
   assign mem_byte_en = wr_s ? lane_be_s : 4'b0000;
   assign mem_wr_data = wr_s ? lane_data_s : {DATA_WIDTH{1'b0}};
   assign mem_addr    = {addr_q[ADDR_WIDTH-1:2], 2'b00};
   assign mem_wr_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
   assign req_ready   = (state_q == IDLE);
   assign resp_valid  = (state_q == RESP);
   assign resp_data   = resp_data_q;
   assign resp_rd     = rd_q;
   assign resp_err    = resp_err_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu with a byte-enabled word memory model.
module tb_lsu;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic [4:0]  req_rd = 5'd0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [31:0] resp_data;
   logic [4:0]  resp_rd;
   logic        resp_err;
   logic [31:0] mem_addr;
   logic [31:0] mem_rd_data;
   logic        mem_wr_en;
   logic [31:0] mem_wr_addr;
   logic [31:0] mem_wr_data;
   logic [3:0]  mem_byte_en;

   int tests = 0;
   int fails = 0;
   int wr_cnt = 0;
   logic [31:0] mem [0:255];

   lsu dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_rd(req_rd), .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_data(resp_data), .resp_rd(resp_rd), .resp_err(resp_err),
      .mem_addr(mem_addr), .mem_rd_data(mem_rd_data), .mem_wr_en(mem_wr_en),
      .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .mem_byte_en(mem_byte_en)
   );

   always #5 clk = ~clk;

   assign mem_rd_data = mem[mem_addr[9:2]];

   // Memory model: byte-enabled write on the rising edge.
   always @(posedge clk) begin
      if (mem_wr_en === 1'b1) begin
         wr_cnt <= wr_cnt + 1;
         for (int i = 0; i < 4; i++)
            if (mem_byte_en[i]) mem[mem_wr_addr[9:2]][8*i +: 8] <= mem_wr_data[8*i +: 8];
      end
   end

   // Drive one request through the full handshake and report what was seen.
   task automatic send_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic [4:0] rd,
                           output logic o_ready, output logic o_wen, output logic [3:0] o_be,
                           output logic [31:0] o_wdata, output logic [31:0] o_waddr,
                           output logic o_rvalid, output logic [31:0] o_rdata,
                           output logic o_err, output logic [4:0] o_rd);
      @(negedge clk);
      req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; req_rd = rd;
      req_valid = 1'b1;
      o_ready = req_ready;
      @(posedge clk); #1;
      req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h1234_5678; req_rd = 5'd31;
      o_wen = mem_wr_en; o_be = mem_byte_en; o_wdata = mem_wr_data; o_waddr = mem_wr_addr;
      @(posedge clk); #1;
      o_rvalid = resp_valid; o_rdata = resp_data; o_err = resp_err; o_rd = resp_rd;
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
   endtask

   logic        rdy, wen, rv, er;
   logic [3:0]  be;
   logic [31:0] wdat, wadr, rdat;
   logic [4:0]  trd;

   task automatic test_reset();
      tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
      tests++; if (resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rd !== 5'd0) begin fails++; $display("FAIL reset_resp got v=%b e=%b rd=%0d want 0/0/0", resp_valid, resp_err, resp_rd); end
      tests++; if (resp_data !== 32'h0) begin fails++; $display("FAIL reset_resp_data got %h want 0", resp_data); end
      tests++; if (mem_wr_en !== 1'b0 || mem_byte_en !== 4'h0 || mem_addr !== 32'h0 || mem_wr_addr !== 32'h0 || mem_wr_data !== 32'h0) begin fails++; $display("FAIL reset_mem got en=%b be=%b a=%h wa=%h wd=%h want zeros", mem_wr_en, mem_byte_en, mem_addr, mem_wr_addr, mem_wr_data); end
   endtask

   task automatic test_sw();
      send_req(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 5'd3, rdy, wen, be, wdat, wadr, rv, rdat, er, trd);
      tests++; if (rdy !== 1'b1) begin fails++; $display("FAIL sw_ready got %b want 1", rdy); end
      tests++; if (wen !== 1'b1 || be !== 4'b1111 || wadr !== 32'h100 || wdat !== 32'hDEADBEEF) begin fails++; $display("FAIL sw_access got en=%b be=%b wa=%h wd=%h want 1/1111/100/deadbeef", wen, be, wadr, wdat); end
      tests++; if (rv !== 1'b1 || er !== 1'b0 || rdat !== 32'h0 || trd !== 5'd3) begin fails++; $display("FAIL sw_resp got v=%b e=%b d=%h rd=%0d want 1/0/0/3", rv, er, rdat, trd); end
      tests++; if (mem[8'h40] !== 32'hDEADBEEF) begin fails++; $display("FAIL sw_mem got %h want deadbeef", mem[8'h40]); end
      tests++; if (wr_cnt !== 1) begin fails++; $display("FAIL sw_one_strobe got %0d want 1", wr_cnt); end
   endtask

   task automatic test_sb();
      send_req(1'b1, 3'b000, 32'h103, 32'h000000A5, 5'd4, rdy, wen, be, wdat, wadr, rv, rdat, er, trd);
      tests++; if (wen !== 1'b1 || be !== 4'b1000 || wdat !== 32'hA5A5A5A5 || wadr !== 32'h100) begin fails++; $display("FAIL sb_access got en=%b be=%b wd=%h wa=%h want 1/1000/a5a5a5a5/100", wen, be, wdat, wadr); end
      tests++; if (mem[8'h40] !== 32'hA5ADBEEF) begin fails++; $display("FAIL sb_mem got %h want a5adbeef", mem[8'h40]); end
      send_req(1'b0, 3'b100, 32'h103, 32'h0, 5'd5, rdy, wen, be, wdat, wadr, rv, rdat, er, trd);
      tests++; if (wen !== 1'b0 || rdat !== 32'h000000A5 || er !== 1'b0 || trd !== 5'd5) begin fails++; $display("FAIL lbu got en=%b d=%h e=%b rd=%0d want 0/000000a5/0/5", wen, rdat, er, trd); end
      send_req(1'b0, 3'b000, 32'h103, 32'h0, 5'd6, rdy, wen, be, wdat, wadr, rv, rdat, er, trd);
      tests++; if (rdat !== 32'hFFFFFFA5 || er !== 1'b0) begin fails++; $display("FAIL lb got d=%h e=%b want ffffffa5/0", rdat, er); end
      send_req(1'b0, 3'b000, 32'h101, 32'h0, 5'd6, rdy, wen, be, wdat, wadr, rv, rdat, er, trd);
      tests++; if (rdat !== 32'hFFFFFFBE) begin fails++; $display("FAIL lb_lane1 got %h want ffffffbe", rdat); end
   endtask

   task automatic test_sh();
      send_req(1'b1, 3'b001, 32'h202, 32'h00008001, 5'd7, rdy, wen, be, wdat, wadr, rv, rdat, er, trd);
      tests++; if (wen !== 1'b1 || be !== 4'b1100 || wdat !== 32'h80018001 || wadr !== 32'h200) begin fails++; $display("FAIL sh_access got en=%b be=%b wd=%h wa=%h want 1/1100/80018001/200", wen, be, wdat, wadr); end
      send_req(1'b0, 3'b001, 32'h202, 32'h0, 5'd8, rdy, wen, be, wdat, wadr, rv, rdat, er, trd);
      tests++; if (rdat !== 32'hFFFF8001 || er !== 1'b0) begin fails++; $display("FAIL lh got d=%h e=%b want ffff8001/0", rdat, er); end
      send_req(1'b0, 3'b101, 32'h202, 32'h0, 5'd8, rdy, wen, be, wdat, wadr, rv, rdat, er, trd);
      tests++; if (rdat !== 32'h00008001 || er !== 1'b0) begin fails++; $display("FAIL lhu got d=%h e=%b want 00008001/0", rdat, er); end
      send_req(1'b0, 3'b001, 32'h100, 32'h0, 5'd8, rdy, wen, be, wdat, wadr, rv, rdat, er, trd);
      tests++; if (rdat !== 32'hFFFFBEEF) begin fails++; $display("FAIL lh_low got %h want ffffbeef", rdat); end
   endtask

   task automatic test_errors();
      int c0;
      c0 = wr_cnt;
      send_req(1'b0, 3'b010, 32'h101, 32'h0, 5'd9, rdy, wen, be, wdat, wadr, rv, rdat, er, trd);
      tests++; if (er !== 1'b1 || rdat !== 32'h0 || rv !== 1'b1) begin fails++; $display("FAIL lw_misalign got e=%b d=%h v=%b want 1/0/1", er, rdat, rv); end
      send_req(1'b1, 3'b001, 32'h203, 32'hFFFF, 5'd10, rdy, wen, be, wdat, wadr, rv, rdat, er, trd);
      tests++; if (er !== 1'b1 || rdat !== 32'h0 || wen !== 1'b0 || be !== 4'b0000) begin fails++; $display("FAIL sh_misalign got e=%b d=%h en=%b be=%b want 1/0/0/0000", er, rdat, wen, be); end
      send_req(1'b0, 3'b110, 32'h100, 32'h0, 5'd11, rdy, wen, be, wdat, wadr, rv, rdat, er, trd);
      tests++; if (er !== 1'b1 || rdat !== 32'h0) begin fails++; $display("FAIL load_f3_110 got e=%b d=%h want 1/0", er, rdat); end
      send_req(1'b1, 3'b100, 32'h100, 32'h55, 5'd12, rdy, wen, be, wdat, wadr, rv, rdat, er, trd);
      tests++; if (er !== 1'b1 || wen !== 1'b0) begin fails++; $display("FAIL store_f3_100 got e=%b en=%b want 1/0", er, wen); end
      tests++; if (wr_cnt !== c0) begin fails++; $display("FAIL err_no_write got %0d strobes want %0d", wr_cnt, c0); end
      tests++; if (mem[8'h40] !== 32'hA5ADBEEF) begin fails++; $display("FAIL err_mem got %h want a5adbeef", mem[8'h40]); end
   endtask

   task automatic test_backpressure();
      @(negedge clk);
      req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100; req_rd = 5'd13; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      // a second request waits while the response is held
      req_we = 1'b0; req_funct3 = 3'b100; req_addr = 32'h103; req_rd = 5'd14; req_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tests++;
         if (resp_valid !== 1'b1 || resp_data !== 32'hA5ADBEEF || resp_rd !== 5'd13 || req_ready !== 1'b0) begin
            fails++; $display("FAIL bp_hold[%0d] got v=%b d=%h rd=%0d rdy=%b want 1/a5adbeef/13/0", i, resp_valid, resp_data, resp_rd, req_ready);
         end
         @(posedge clk); #1;
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      tests++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin fails++; $display("FAIL bp_release got rdy=%b v=%b want 1/0", req_ready, resp_valid); end
      @(posedge clk); #1;
      req_valid = 1'b0;
      tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL bp_next_accept got rdy=%b want 0", req_ready); end
      @(posedge clk); #1;
      tests++; if (resp_valid !== 1'b1 || resp_data !== 32'h000000A5 || resp_rd !== 5'd14) begin fails++; $display("FAIL bp_next_resp got v=%b d=%h rd=%0d want 1/000000a5/14", resp_valid, resp_data, resp_rd); end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      send_req(1'b1, 3'b010, 32'h300, 32'h11111111, 5'd15, rdy, wen, be, wdat, wadr, rv, rdat, er, trd);
      @(negedge clk);
      req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h300; req_wdata = 32'h22222222; req_rd = 5'd16; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      tests++; if (mem_wr_en !== 1'b1) begin fails++; $display("FAIL rst_pre_strobe got %b want 1", mem_wr_en); end
      #2 rst_n = 1'b0;
      #1;
      tests++; if (mem_wr_en !== 1'b0 || mem_byte_en !== 4'h0 || mem_wr_data !== 32'h0 || mem_addr !== 32'h0 || mem_wr_addr !== 32'h0) begin fails++; $display("FAIL rst_mid_mem got en=%b be=%b wd=%h a=%h want zeros", mem_wr_en, mem_byte_en, mem_wr_data, mem_addr); end
      tests++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_data !== 32'h0 || resp_rd !== 5'd0 || resp_err !== 1'b0) begin fails++; $display("FAIL rst_mid_resp got rdy=%b v=%b d=%h rd=%0d e=%b want 1/0/0/0/0", req_ready, resp_valid, resp_data, resp_rd, resp_err); end
      @(negedge clk);
      rst_n = 1'b1;
      tests++; if (mem[8'hC0] !== 32'h11111111) begin fails++; $display("FAIL rst_mid_word got %h want 11111111", mem[8'hC0]); end
      send_req(1'b0, 3'b010, 32'h300, 32'h0, 5'd17, rdy, wen, be, wdat, wadr, rv, rdat, er, trd);
      tests++; if (rdy !== 1'b1 || rdat !== 32'h11111111 || trd !== 5'd17) begin fails++; $display("FAIL rst_after_lw got rdy=%b d=%h rd=%0d want 1/11111111/17", rdy, rdat, trd); end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      @(negedge clk);
      rst_n = 1'b1;
      test_sw();
      test_sb();
      test_sh();
      test_errors();
      test_backpressure();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/lsu.md
# lsu

Load/store unit: the initiator side of the core's data-memory port. It accepts one load or store request at a time from the execute stage, checks alignment, and drives a word-aligned access with byte enables into the byte-addressed data memory. That memory has a combinational read and a byte-enabled write on the clock edge. The unit then returns a sign- or zero-extended load result, or a store completion, to writeback over a valid/ready handshake.

## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, data width; fixed at 32, 4 byte lanes
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  DATA_WIDTH  store data, right-justified
- req_rd  in  5  destination tag, passed through unchanged
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts response
- resp_data  out  DATA_WIDTH  extended load data; 0 for stores and errors
- resp_rd  out  5  tag of the completed request
- resp_err  out  1  misaligned or illegal funct3
- mem_addr  out  ADDR_WIDTH  word-aligned read address
- mem_rd_data  in  DATA_WIDTH  combinational read data for mem_addr
- mem_wr_en  out  1  write strobe
- mem_wr_addr  out  ADDR_WIDTH  word-aligned write address
- mem_wr_data  out  DATA_WIDTH  lane-replicated store data
- mem_byte_en  out  4  lane enables; bit i covers bits [8i+7:8i]

## Operation
- FSM states: IDLE, ACCESS, RESP.
- Reset state is IDLE.
- IDLE:
  - req_ready=1.
  - On req_valid, latch we, funct3, addr, wdata and rd, then go to ACCESS.
- ACCESS:
  - req_ready=0.
  - mem_addr and mem_wr_addr = {addr[31:2],2'b00}.
  - Load: capture the extended result into resp_data.
  - Store with no error: mem_wr_en=1 for exactly this one cycle.
  - Always go to RESP next.
- RESP:
  - resp_valid=1.
  - resp_data, resp_rd and resp_err are held stable until resp_ready=1.
  - On resp_ready=1, go to IDLE.
- Error conditions:
  - H/HU with addr[0]=1.
  - W with addr[1:0]≠00.
  - Load funct3 ∉ {000,001,010,100,101}.
  - Store funct3 ∉ {000,001,010}.
- On error: no write, resp_err=1, resp_data=0.
- Store lanes:
  - SB: wr_data = {4{wdata[7:0]}}, byte_en = 0001 << addr[1:0].
  - SH: wr_data = {2{wdata[15:0]}}, byte_en = 0011 (addr[1]=0) or 1100 (addr[1]=1).
  - SW: wr_data = wdata, byte_en = 1111.
- Load extraction:
  - s = mem_rd_data >> (8·addr[1:0]).
  - LB: sign-extend s[7:0].
  - LBU: zero-extend s[7:0].
  - LH: sign-extend s[15:0].
  - LHU: zero-extend s[15:0].
  - LW: s.
- Outside ACCESS: mem_wr_en=0, mem_byte_en=0000, mem_wr_data=0.

## Timing
- Reset values:
  - req_ready=1.
  - resp_valid=0, resp_data=0, resp_rd=0, resp_err=0.
  - mem_wr_en=0, mem_byte_en=0, mem_addr=0, mem_wr_addr=0, mem_wr_data=0.
- Latency:
  - Request accepted at edge N.
  - ACCESS during cycle N..N+1; the memory write commits at edge N+1.
  - resp_valid asserted from edge N+1 onward.
- Throughput: one request per 3 cycles minimum.
- Back-pressure: with resp_ready=0, RESP holds indefinitely and req_ready stays 0.
- A request presented outside IDLE is not accepted. The requester holds it until req_ready=1.
- Request inputs are ignored after acceptance. Latched values only are used.
- Reset asserted mid-operation:
  - Immediate return to IDLE.
  - mem_wr_en deasserts asynchronously, so no partial write commits after reset.
  - Any in-flight response is dropped.
- Address wrap: only addr[31:2] is forwarded. The unit never issues an access crossing a word boundary.

## Test plan
- SW addr 0x100, wdata 0xDEADBEEF -> one cycle with mem_wr_en=1, byte_en=1111, wr_addr=0x100; then resp_valid, resp_err=0, resp_data=0.
- SB addr 0x103, wdata 0x000000A5 -> byte_en=1000, wr_data=0xA5A5A5A5; a following LBU at 0x103 returns 0x000000A5 and LB returns 0xFFFFFFA5.
- SH addr 0x202, wdata 0x8001, then LH 0x202 -> byte_en=1100; LH returns 0xFFFF8001; LHU returns 0x00008001.
- LW addr 0x101 and SH addr 0x203 -> resp_err=1, resp_data=0, mem_wr_en never asserted.
- Load with funct3=110 -> resp_err=1.
- LW with resp_ready held 0 for 5 cycles -> resp_valid and resp_data stable throughout, req_ready=0; the next request is accepted only after the handshake.
- rst_n pulsed low during ACCESS of an SW -> mem_wr_en drops immediately, the word at the target address is unchanged, and all outputs return to their reset values.
